// File: rtl/sensor_pkg.sv
// Shared sensor definitions: input count and bit positions of each raw sensor/switch.
// Reused by the irrigation controller top level so both sides agree on the bit map.
package sensor_pkg;

    localparam int N_SENSORS = 7;

    localparam int IDX_HIGH     = 0;
    localparam int IDX_MIDDLE   = 1;
    localparam int IDX_LOW      = 2;
    localparam int IDX_SOIL     = 3;
    localparam int IDX_AIR      = 4;
    localparam int IDX_TEMP     = 5;
    localparam int IDX_SELECTOR = 6;

    typedef logic [N_SENSORS-1:0] sensor_vec_t;

endpackage

// File: rtl/debounce_bit.sv
// One input lane: flip-flop synchroniser, stability counter and clean level register.
// New levels are accepted only after STABLE_SAMPLES consecutive mismatching sample ticks.
module debounce_bit #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_SAMPLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic sample_tick,
    output logic clean,
    output logic changed
);

    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   sync;
    logic [CW-1:0]          cnt;

    // Synchroniser stage: raw is asynchronous, only the last flop is used downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_p0[SYNC_STAGES-1];

    // Debounce stage: any matching tick discards the partial count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            clean   <= 1'b0;
            changed <= 1'b0;
        end else if (sample_tick) begin
            if (sync == clean) begin
                cnt     <= '0;
                changed <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                cnt     <= '0;
                clean   <= sync;
                changed <= 1'b1;
            end else begin
                cnt     <= cnt + 1'b1;
                changed <= 1'b0;
            end
        end else begin
            changed <= 1'b0;
        end
    end

endmodule

// File: rtl/sensor_debouncer.sv
// Synchronises and debounces the seven raw irrigation sensor/switch inputs.
// A single prescaler paces all lanes; each lane produces a clean level and a change pulse.
module sensor_debouncer
    import sensor_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SENSORS-1:0] raw_in,
    output logic [N_SENSORS-1:0] clean_out,
    output logic [N_SENSORS-1:0] changed,
    output logic                 sample_tick
);

    localparam int PW = $clog2(SAMPLE_DIV + 1);
    localparam logic [PW-1:0] PS_LAST = PW'(SAMPLE_DIV - 1);

    logic [PW-1:0] ps_cnt;

    // Prescaler stage: tick is registered, so it appears the cycle after the terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt      <= '0;
            sample_tick <= 1'b0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt      <= '0;
            sample_tick <= 1'b1;
        end else begin
            ps_cnt      <= ps_cnt + 1'b1;
            sample_tick <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_lane
        debounce_bit #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .raw        (raw_in[i]),
            .sample_tick(sample_tick),
            .clean      (clean_out[i]),
            .changed    (changed[i])
        );
    end

endmodule

// File: tb/tb_sensor_debouncer.sv
// Directed bench for sensor_debouncer: main instance with SAMPLE_DIV=4, second with SAMPLE_DIV=1.
module tb_sensor_debouncer;
    import sensor_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] raw_in, raw1;
    logic [6:0] clean_out, changed, clean1, changed1;
    logic       sample_tick, tick1;

    int n_checks = 0;
    int n_pass   = 0;
    int lat, early, seen, bad_clean, bad_chg;

    sensor_debouncer #(.SYNC_STAGES(2), .SAMPLE_DIV(4), .STABLE_SAMPLES(3)) dut (
        .clk(clk), .rst(rst), .raw_in(raw_in),
        .clean_out(clean_out), .changed(changed), .sample_tick(sample_tick)
    );

    sensor_debouncer #(.SYNC_STAGES(2), .SAMPLE_DIV(1), .STABLE_SAMPLES(3)) dut1 (
        .clk(clk), .rst(rst), .raw_in(raw1),
        .clean_out(clean1), .changed(changed1), .sample_tick(tick1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (sample_tick) found = 1;
        end
        check("tick_seen", found, 1);
    endtask

    task automatic wait_ticks(input int n);
        int cnt = 0;
        for (int i = 0; i < 200 && cnt < n; i++) begin
            step();
            if (sample_tick) cnt++;
        end
        check("ticks_counted", cnt, n);
    endtask

    // Waits for clean_out to leave value `from`; lat=0 if it never does
    task automatic wait_change(input logic [6:0] from);
        lat = 0;
        early = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (clean_out != from) begin
                lat = i;
                break;
            end
            if (changed != 0) early++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        raw_in = 7'h7F;
        raw1   = 7'h7F;

        // 1. reset holds everything low
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_clean", clean_out, 7'h00);
            check("rst_changed", changed, 7'h00);
            check("rst_tick", sample_tick, 1'b0);
            check("rst_tick_div1", tick1, 1'b0);
            check("rst_clean_div1", clean1, 7'h00);
        end
        raw_in = 7'h00;
        raw1   = 7'h00;
        rst    = 1'b0;

        // prescaler period: exactly 2 ticks in any 8 cycles
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (sample_tick) seen++;
        end
        check("tick_period", seen, 2);

        // 2. clean step on bit 0, aligned to a tick: evals at +5,+9,+13
        wait_tick();
        raw_in = 7'h01;
        wait_change(7'h00);
        check("step_latency", lat, 13);
        check("step_no_early_pulse", early, 0);
        check("step_clean", clean_out, 7'h01);
        check("step_changed", changed, 7'h01);
        step();
        check("step_changed_clear", changed, 7'h00);
        check("step_clean_hold", clean_out, 7'h01);

        // 3. glitch on bit 3 lasting only 2 ticks
        wait_tick();
        raw_in = 7'h09;
        wait_ticks(2);
        raw_in = 7'h01;
        bad_clean = 0;
        bad_chg = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (clean_out[IDX_SOIL]) bad_clean++;
            if (changed[IDX_SOIL]) bad_chg++;
        end
        check("glitch_clean3", bad_clean, 0);
        check("glitch_changed3", bad_chg, 0);
        check("glitch_other_bits", clean_out, 7'h01);

        // 4. return to zero, then simultaneous rise on bits 0,2,6
        wait_tick();
        raw_in = 7'h00;
        wait_change(7'h01);
        check("fall_latency", lat, 13);
        check("fall_changed", changed, 7'h01);
        wait_tick();
        raw_in = 7'h45;
        wait_change(7'h00);
        check("simul_latency", lat, 13);
        check("simul_clean", clean_out, 7'h45);
        check("simul_changed", changed, 7'h45);
        step();
        check("simul_changed_clear", changed, 7'h00);

        // 5. reset in the middle of a partial count on bit 5
        rst    = 1'b1;
        raw_in = 7'h00;
        step();
        check("rst2_clean", clean_out, 7'h00);
        rst = 1'b0;
        wait_tick();
        raw_in = 7'h20;
        wait_ticks(2);
        check("midcount_clean", clean_out, 7'h00);
        rst = 1'b1;
        step();
        check("midrst_clean", clean_out, 7'h00);
        check("midrst_changed", changed, 7'h00);
        check("midrst_tick", sample_tick, 1'b0);
        rst = 1'b0;
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (clean_out[IDX_TEMP]) begin
                lat = i;
                break;
            end
            if (sample_tick) seen++;
        end
        check("midrst_latency", lat, 13);
        check("midrst_ticks_before", seen, 3);
        check("midrst_changed5", changed, 7'h20);

        // 6. SAMPLE_DIV=1: tick held high, exact SYNC_STAGES+STABLE_SAMPLES latency
        for (int i = 0; i < 3; i++) begin
            step();
            check("div1_tick", tick1, 1'b1);
        end
        raw1 = 7'h40;
        bad_clean = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i < 5 && clean1 != 7'h00) bad_clean++;
            if (i == 5) begin
                check("div1_clean", clean1, 7'h40);
                check("div1_changed", changed1, 7'h40);
            end
            if (i == 6) begin
                check("div1_changed_clear", changed1, 7'h00);
                check("div1_clean_hold", clean1, 7'h40);
            end
        end
        check("div1_no_early", bad_clean, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
